// File: rtl/prod_accum_pkg.sv
// Shared types and widths for the product accumulator.
package prod_accum_pkg;

  // Width of one incoming 4x3-bit product term.
  localparam int PROD_W = 7;
  // Width of the term counter; holds up to 15 terms.
  localparam int CNT_W  = 4;

  // ACCUM collects terms; HOLD presents a finished result to the consumer.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage : prod_accum_pkg

// File: rtl/prod_accum_acc_adder.sv
// Unsigned W-bit adder that also reports the carry out of the top bit.
module acc_adder #(
  parameter int W = 10
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout
);

  // Widen by one bit so the carry lands in the MSB of the result.
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b};
  end

endmodule : acc_adder

// File: rtl/prod_accum.sv
// Accumulates up to TERMS product beats into one result, then holds the
// result until the consumer takes it. A clr or reset discards everything.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int TERMS = 8,
  parameter int ACC_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  localparam logic [CNT_W-1:0] TERMS_C = CNT_W'(TERMS);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;

  logic [ACC_W-1:0]   add_sum;
  logic               add_cout;
  logic [CNT_W-1:0]   count_inc;
  logic               accept;
  logic               final_beat;
  logic               drain;

  // Running sum plus the zero-extended incoming product.
  acc_adder #(
    .W (ACC_W)
  ) u_adder (
    .a    (sum_q),
    .b    (ACC_W'(in_prod)),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Handshake qualifiers shared by the state and datapath logic.
  always_comb begin
    count_inc  = count_q + CNT_W'(1);
    accept     = in_valid && (state_q == ACCUM) && !clr;
    final_beat = accept && ((count_inc == TERMS_C) || in_last);
    drain      = (state_q == HOLD) && out_ready;
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: clr wins, then the final beat, then the drain.
  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ACCUM;
    end else if (final_beat) begin
      state_d = HOLD;
    end else if (drain) begin
      state_d = ACCUM;
    end
  end

  // Accumulator datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Datapath next values: clear on abort or handoff, update on accept.
  always_comb begin
    sum_d   = sum_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr || drain) begin
      sum_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (accept) begin
      sum_d   = add_sum;
      count_d = count_inc;
      ovf_d   = ovf_q | add_cout;
    end
  end

  // Outputs decoded from state only; result fields come straight from flops.
  always_comb begin
    in_ready  = rst_n && (state_q == ACCUM) && !clr;
    out_valid = (state_q == HOLD);
    out_sum   = sum_q;
    out_count = count_q;
    out_ovf   = ovf_q;
  end

endmodule : prod_accum

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum: default, narrow (ACC_W=7, TERMS=2) and
// single-term instances share one stimulus bus; each test resets first.
module tb_prod_accum;
  import prod_accum_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              clr;
  logic              in_valid;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              out_ready;

  logic              d_in_ready, d_out_valid, d_out_ovf;
  logic [9:0]        d_out_sum;
  logic [CNT_W-1:0]  d_out_count;

  logic              s_in_ready, s_out_valid, s_out_ovf;
  logic [6:0]        s_out_sum;
  logic [CNT_W-1:0]  s_out_count;

  logic              o_in_ready, o_out_valid, o_out_ovf;
  logic [9:0]        o_out_sum;
  logic [CNT_W-1:0]  o_out_count;

  int checks;
  int failures;

  prod_accum dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .in_ready(d_in_ready), .in_prod(in_prod), .in_last(in_last),
    .out_valid(d_out_valid), .out_ready(out_ready), .out_sum(d_out_sum),
    .out_count(d_out_count), .out_ovf(d_out_ovf)
  );

  prod_accum #(.TERMS(2), .ACC_W(7)) dut_s (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .in_ready(s_in_ready), .in_prod(in_prod), .in_last(in_last),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_sum(s_out_sum),
    .out_count(s_out_count), .out_ovf(s_out_ovf)
  );

  prod_accum #(.TERMS(1), .ACC_W(10)) dut_o (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .in_ready(o_in_ready), .in_prod(in_prod), .in_last(in_last),
    .out_valid(o_out_valid), .out_ready(out_ready), .out_sum(o_out_sum),
    .out_count(o_out_count), .out_ovf(o_out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after a falling edge; outputs are read there too.
  task automatic do_reset();
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Present one beat for one rising edge, then drop in_valid.
  task automatic beat(input logic [PROD_W-1:0] p, input logic last);
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_prod = '0;
    in_last = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (d_in_ready !== 1'b0) begin
      failures++; $display("FAIL reset_in_ready: got %b expected 0", d_in_ready);
    end
    checks++;
    if ({d_out_valid, d_out_ovf, d_out_sum, d_out_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b sum=%0d cnt=%0d ovf=%b expected all 0",
               d_out_valid, d_out_sum, d_out_count, d_out_ovf);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (d_in_ready !== 1'b1) begin
      failures++; $display("FAIL release_in_ready: got %b expected 1", d_in_ready);
    end
  endtask

  task automatic test_full_run();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      beat(7'd105, 1'b0);
      checks++;
      if (d_out_valid !== 1'b0 || d_out_count !== 4'(i + 1)) begin
        failures++;
        $display("FAIL full_partial%0d: got v=%b cnt=%0d expected v=0 cnt=%0d",
                 i, d_out_valid, d_out_count, i + 1);
      end
    end
    beat(7'd105, 1'b0);
    checks++;
    if (d_out_valid !== 1'b1 || d_out_sum !== 10'd840 || d_out_count !== 4'd8 ||
        d_out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL full_result: got v=%b sum=%0d cnt=%0d ovf=%b expected v=1 sum=840 cnt=8 ovf=0",
               d_out_valid, d_out_sum, d_out_count, d_out_ovf);
    end
    checks++;
    if (d_in_ready !== 1'b0) begin
      failures++; $display("FAIL full_bubble: got in_ready=%b expected 0", d_in_ready);
    end
    @(negedge clk);
    checks++;
    if (d_out_valid !== 1'b0 || d_in_ready !== 1'b1 || d_out_sum !== 10'd0) begin
      failures++;
      $display("FAIL full_drain: got v=%b rdy=%b sum=%0d expected v=0 rdy=1 sum=0",
               d_out_valid, d_in_ready, d_out_sum);
    end
  endtask

  task automatic test_last();
    do_reset();
    beat(7'd12, 1'b0);
    beat(7'd30, 1'b0);
    checks++;
    if (d_out_valid !== 1'b0 || d_out_sum !== 10'd42) begin
      failures++;
      $display("FAIL last_partial: got v=%b sum=%0d expected v=0 sum=42", d_out_valid, d_out_sum);
    end
    beat(7'd7, 1'b1);
    checks++;
    if (d_out_valid !== 1'b1 || d_out_sum !== 10'd49 || d_out_count !== 4'd3) begin
      failures++;
      $display("FAIL last_result: got v=%b sum=%0d cnt=%0d expected v=1 sum=49 cnt=3",
               d_out_valid, d_out_sum, d_out_count);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (d_out_valid !== 1'b0) begin
      failures++; $display("FAIL last_drain: got v=%b expected 0", d_out_valid);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    beat(7'd100, 1'b0);
    checks++;
    if (s_out_valid !== 1'b0 || s_out_ovf !== 1'b0 || s_out_sum !== 7'd100) begin
      failures++;
      $display("FAIL ovf_first: got v=%b sum=%0d ovf=%b expected v=0 sum=100 ovf=0",
               s_out_valid, s_out_sum, s_out_ovf);
    end
    beat(7'd50, 1'b0);
    checks++;
    if (s_out_valid !== 1'b1 || s_out_sum !== 7'd22 || s_out_count !== 4'd2 ||
        s_out_ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_result: got v=%b sum=%0d cnt=%0d ovf=%b expected v=1 sum=22 cnt=2 ovf=1",
               s_out_valid, s_out_sum, s_out_count, s_out_ovf);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    beat(7'd3, 1'b0);
    beat(7'd4, 1'b0);
    checks++;
    if (s_out_valid !== 1'b1 || s_out_sum !== 7'd7 || s_out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_next: got v=%b sum=%0d ovf=%b expected v=1 sum=7 ovf=0",
               s_out_valid, s_out_sum, s_out_ovf);
    end
  endtask

  task automatic test_single_term();
    do_reset();
    beat(7'd77, 1'b0);
    checks++;
    if (o_out_valid !== 1'b1 || o_out_sum !== 10'd77 || o_out_count !== 4'd1) begin
      failures++;
      $display("FAIL single_term: got v=%b sum=%0d cnt=%0d expected v=1 sum=77 cnt=1",
               o_out_valid, o_out_sum, o_out_count);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    beat(7'd1, 1'b0);
    beat(7'd2, 1'b0);
    beat(7'd3, 1'b1);
    in_valid = 1'b1; in_prod = 7'd99; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (d_in_ready !== 1'b0 || d_out_valid !== 1'b1 || d_out_sum !== 10'd6 ||
          d_out_count !== 4'd3) begin
        failures++;
        $display("FAIL hold_cycle%0d: got rdy=%b v=%b sum=%0d cnt=%0d expected rdy=0 v=1 sum=6 cnt=3",
                 i, d_in_ready, d_out_valid, d_out_sum, d_out_count);
      end
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (d_out_valid !== 1'b0 || d_out_count !== 4'd0) begin
      failures++;
      $display("FAIL hold_release: got v=%b cnt=%0d expected v=0 cnt=0", d_out_valid, d_out_count);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (d_out_valid !== 1'b0) begin
      failures++; $display("FAIL hold_single_handshake: got v=%b expected 0", d_out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_clr();
    do_reset();
    out_ready = 1'b1;
    repeat (4) beat(7'd10, 1'b0);
    clr = 1'b1; in_valid = 1'b1; in_prod = 7'd50;
    #1;
    checks++;
    if (d_in_ready !== 1'b0) begin
      failures++; $display("FAIL clr_ready: got %b expected 0", d_in_ready);
    end
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    checks++;
    if (d_out_valid !== 1'b0 || d_out_sum !== 10'd0 || d_out_count !== 4'd0) begin
      failures++;
      $display("FAIL clr_discard: got v=%b sum=%0d cnt=%0d expected v=0 sum=0 cnt=0",
               d_out_valid, d_out_sum, d_out_count);
    end
    out_ready = 1'b0;
    repeat (8) beat(7'd1, 1'b0);
    checks++;
    if (d_out_valid !== 1'b1 || d_out_sum !== 10'd8 || d_out_count !== 4'd8) begin
      failures++;
      $display("FAIL clr_after: got v=%b sum=%0d cnt=%0d expected v=1 sum=8 cnt=8",
               d_out_valid, d_out_sum, d_out_count);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (d_out_valid !== 1'b0 || d_out_sum !== 10'd0) begin
      failures++;
      $display("FAIL clr_in_hold: got v=%b sum=%0d expected v=0 sum=0", d_out_valid, d_out_sum);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) beat(7'd5, 1'b0);
    beat(7'd5, 1'b1);
    checks++;
    if (d_out_valid !== 1'b1 || d_out_sum !== 10'd40 || d_out_count !== 4'd8) begin
      failures++;
      $display("FAIL b2b_first: got v=%b sum=%0d cnt=%0d expected v=1 sum=40 cnt=8",
               d_out_valid, d_out_sum, d_out_count);
    end
    @(negedge clk);
    checks++;
    if (d_out_valid !== 1'b0 || d_out_count !== 4'd0) begin
      failures++;
      $display("FAIL b2b_no_empty: got v=%b cnt=%0d expected v=0 cnt=0", d_out_valid, d_out_count);
    end
    beat(7'd20, 1'b0);
    beat(7'd21, 1'b1);
    checks++;
    if (d_out_valid !== 1'b1 || d_out_sum !== 10'd41 || d_out_count !== 4'd2) begin
      failures++;
      $display("FAIL b2b_second: got v=%b sum=%0d cnt=%0d expected v=1 sum=41 cnt=2",
               d_out_valid, d_out_sum, d_out_count);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (8) beat(7'd105, 1'b0);
    checks++;
    if (d_out_valid !== 1'b1 || d_out_sum !== 10'd840) begin
      failures++;
      $display("FAIL areset_setup: got v=%b sum=%0d expected v=1 sum=840", d_out_valid, d_out_sum);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (d_out_valid !== 1'b0 || d_out_sum !== 10'd0 || d_out_count !== 4'd0 ||
        d_out_ovf !== 1'b0 || d_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL areset_immediate: got v=%b sum=%0d cnt=%0d ovf=%b rdy=%b expected all 0",
               d_out_valid, d_out_sum, d_out_count, d_out_ovf, d_in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    repeat (8) beat(7'd2, 1'b0);
    checks++;
    if (d_out_valid !== 1'b1 || d_out_sum !== 10'd16 || d_out_count !== 4'd8) begin
      failures++;
      $display("FAIL areset_rerun: got v=%b sum=%0d cnt=%0d expected v=1 sum=16 cnt=8",
               d_out_valid, d_out_sum, d_out_count);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_full_run();
    test_last();
    test_overflow();
    test_single_term();
    test_backpressure();
    test_clr();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_prod_accum

// File: doc/prod_accum.md
PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 Parameter TERMS, default 8, products summed per result, legal range 1..15.
REQ-002 Parameter ACC_W, default 10, accumulator width in bits, legal range 7..16.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 clr  input  1  synchronous abort: discards partial sum and any pending result.
REQ-006 in_valid  input  1  in_prod is valid this cycle.
REQ-007 in_ready  output  1  block accepts in_prod this cycle.
REQ-008 in_prod  input  7  unsigned 4x3-bit product, values 0..105 (and up to 127 tolerated).
REQ-009 in_last  input  1  marks the beat as the final term of the current result, qualified by in_valid.
REQ-010 out_valid  output  1  result fields are valid.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 out_sum  output  ACC_W  accumulated sum of the terms.
REQ-013 out_count  output  4  number of terms in out_sum, 1..TERMS.
REQ-014 out_ovf  output  1  sticky: a carry out of ACC_W occurred during this result.

Function
REQ-015 The FSM SHALL have exactly two states: ACCUM (collecting) and HOLD (result presented).
REQ-016 A beat is accepted when in_valid and in_ready are both 1 on a rising edge; there are no other accepts.
REQ-017 in_ready SHALL be 1 only when state is ACCUM and clr is 0; it is combinational from state and clr only, never from in_valid.
REQ-018 On accept: sum <= sum + zero-extended in_prod, modulo 2^ACC_W; count <= count + 1; ovf <= ovf OR carry-out.
REQ-019 When the accepted beat brings count to TERMS, or carries in_last=1, the FSM SHALL move to HOLD on the same edge, with the updated sum, count and ovf registered.
REQ-020 out_valid SHALL be 1 exactly when state is HOLD.
REQ-021 out_sum, out_count and out_ovf SHALL be held stable while out_valid=1 and out_ready=0.
REQ-022 On out_valid and out_ready both 1: sum, count and ovf clear to 0, and the FSM returns to ACCUM on that edge. in_ready rises the following cycle, so there is one bubble cycle per result.
REQ-023 Latency: the result is visible one cycle after the edge that accepts the final beat.
REQ-024 in_valid is ignored in HOLD, and in_prod and in_last are ignored whenever no accept occurs.
REQ-025 clr=1 on an edge: the FSM goes to ACCUM with sum, count and ovf at 0. This holds in either state and takes priority over a simultaneous accept or output handshake; no beat is accepted that cycle.
REQ-026 With TERMS=1, every accepted beat goes directly to HOLD.
REQ-027 in_last together with count reaching TERMS on the same beat SHALL produce a single result, with no extra empty result.
REQ-028 There is no result with count 0; a clr during ACCUM produces no output.

Reset
REQ-029 While rst_n=0: the FSM is in ACCUM, internal sum/count/ovf are 0, out_valid=0, out_sum=0, out_count=0, out_ovf=0; in_ready=0 while rst_n=0 and 1 from the first cycle after release.
REQ-030 Reset asserted mid-accumulation or in HOLD SHALL discard all partial and pending data immediately, without waiting for a clock edge.

Structure
REQ-031 Package prod_accum_pkg SHALL hold the state enumeration (ACCUM, HOLD), PROD_W=7 and CNT_W=4.
REQ-032 One sub-module, acc_adder, SHALL implement an ACC_W-bit unsigned adder with a carry-out; everything else is local to prod_accum.
REQ-033 All outputs SHALL be registered, or decoded from the state register only; there is no combinational path from in_* to out_*.

Verification
REQ-034 Defaults; 8 beats of 105 with out_ready=1 -> one result: out_sum=840, out_count=8, out_ovf=0; then in_ready returns after the single bubble.
REQ-035 Beats 12, 30, 7 with in_last on the third -> out_sum=49, out_count=3, one cycle after the third accept.
REQ-036 ACC_W=7, TERMS=2; beats 100 and 50 -> out_sum=22, out_ovf=1; the next result starts with out_ovf=0.
REQ-037 HOLD with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 throughout, outputs frozen; out_ready=1 -> exactly one handshake.
REQ-038 clr asserted after 4 beats, in the same cycle as in_valid -> beat not accepted, no result; the next 8 beats of 1 give out_sum=8.
REQ-039 rst_n pulsed low between clock edges during HOLD -> out_valid=0 immediately and all outputs 0; a fresh 8-beat run after release is correct.
